// File: rtl/sequenciador_ula.sv
// sequenciador_ula: four-state multicycle sequencer for the 16-bit ULA.
// It accepts one instruction at a time over a valid/ready handshake and owns
// an 8 x 16 register bank. It drives registered operands and an opcode into
// an external combinational ULA, captures the result and writes it back.
//
// Optional feature macro: FLAGS_EN.
//   When defined, Zero and Neg are registered flags taken from the value
//   written by each legal writeback.
//   When undefined, no flag registers exist and both ports are tied to 0.
module sequenciador_ula #(
  parameter logic [15:0] RESET_VALUE = 16'h0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] Instr,
  input  logic        InstrValid,
  output logic        InstrReady,
  output logic        Done,
  output logic        IllegalOp,
  output logic [15:0] UlaA,
  output logic [15:0] UlaB,
  output logic [2:0]  UlaOp,
  input  logic [15:0] UlaResul,
  input  logic [2:0]  RegSel,
  output logic [15:0] RegData,
  output logic        Zero,
  output logic        Neg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_MVI  = 3'b011;
  localparam logic [2:0] OP_MV   = 3'b111;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ula_a_q, ula_a_d;
  logic [15:0] ula_b_q, ula_b_d;
  logic [2:0]  ula_op_q, ula_op_d;
  logic [15:0] res_q, res_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
  logic [15:0] bank_q [8];
  logic [15:0] bank_d [8];

`ifdef FLAGS_EN
  logic        zero_q, zero_d;
  logic        neg_q, neg_d;
`endif

  // Fields of the latched instruction word.
  logic [2:0]  ir_op;
  logic [2:0]  ir_rx;
  logic [2:0]  ir_ry;
  logic [6:0]  ir_imm7;
  logic        ir_legal;

  assign ir_op   = ir_q[15:13];
  assign ir_rx   = ir_q[12:10];
  assign ir_ry   = ir_q[9:7];
  assign ir_imm7 = ir_q[6:0];

  // Only five opcodes are implemented; the rest are reported as illegal.
  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_NAND, OP_MVI, OP_MV: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  endfunction

  // ULA opcode presented for a given instruction opcode: mvi reuses the ULA
  // pass-B path, and illegal opcodes park the ULA on add (result is dropped).
  function automatic logic [2:0] ula_sel(input logic [2:0] op);
    if (op == OP_MVI) begin
      ula_sel = OP_MV;
    end else if (op_legal(op)) begin
      ula_sel = op;
    end else begin
      ula_sel = OP_ADD;
    end
  endfunction

  assign ir_legal = op_legal(ir_op);

  // Next-state, operand, result and writeback logic of the sequencer.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    ula_a_d   = ula_a_q;
    ula_b_d   = ula_b_q;
    ula_op_d  = ula_op_q;
    res_d     = res_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    bank_d    = bank_q;
`ifdef FLAGS_EN
    zero_d    = zero_q;
    neg_d     = neg_q;
`endif
    case (state_q)
      IDLE: begin
        // Instr and InstrValid only matter here; the word is latched so the
        // source is free to change it after the handshake edge.
        if (InstrValid) begin
          ir_d    = Instr;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Both operands are read from the pre-write bank, so rx == ry sees
        // the same value on A and B.
        ula_a_d  = bank_q[ir_rx];
        ula_b_d  = (ir_op == OP_MVI) ? {9'b0, ir_imm7} : bank_q[ir_ry];
        ula_op_d = ula_sel(ir_op);
        state_d  = EXEC;
      end
      EXEC: begin
        res_d     = UlaResul;
        done_d    = 1'b1;
        illegal_d = ~ir_legal;
        state_d   = WB;
      end
      WB: begin
        if (ir_legal) begin
          bank_d[ir_rx] = res_q;
`ifdef FLAGS_EN
          zero_d = (res_q == 16'h0000);
          neg_d  = res_q[15];
`endif
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight instruction.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      ir_q      <= 16'h0000;
      ula_a_q   <= 16'h0000;
      ula_b_q   <= 16'h0000;
      ula_op_q  <= 3'b000;
      res_q     <= 16'h0000;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        bank_q[i] <= RESET_VALUE;
      end
`ifdef FLAGS_EN
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      ula_a_q   <= ula_a_d;
      ula_b_q   <= ula_b_d;
      ula_op_q  <= ula_op_d;
      res_q     <= res_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      bank_q    <= bank_d;
`ifdef FLAGS_EN
      zero_q    <= zero_d;
      neg_q     <= neg_d;
`endif
    end
  end

  assign InstrReady = (state_q == IDLE);
  assign Done       = done_q;
  assign IllegalOp  = illegal_q;
  assign UlaA       = ula_a_q;
  assign UlaB       = ula_b_q;
  assign UlaOp      = ula_op_q;
  assign RegData    = bank_q[RegSel];

`ifdef FLAGS_EN
  assign Zero = zero_q;
  assign Neg  = neg_q;
`else
  assign Zero = 1'b0;
  assign Neg  = 1'b0;
`endif

endmodule
